jtopl_pg_enc: RTL and testbench

//  Inverse of the phase-generator increment path: takes a target 17-bit phase

---
 rtl/jtopl_pg_enc.sv | 117 +++++++++++
 tb/tb_jtopl_pg_enc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_pg_enc.sv
// jtopl_pg_enc: inverse of the OPL phase-increment path. It turns a 17-bit target
//   phinc into a block/fnum pair such that phinc ~= (fnum << block) >> 1, keeping
//   as many fnum bits as possible. Latency is k+2 cycles from accept to out_valid,
//   where k (0..7) is the number of normalisation shifts. in_ready is high only in
//   IDLE; the result is held with out_valid high until out_ready is seen.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   request handshake, phinc_in is the 17-bit target
//   out_valid, out_ready result handshake, block[2:0] / fnum[9:0] / sat
module jtopl_pg_enc (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [16:0] phinc_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  block,
   output logic [9:0]  fnum,
   output logic        sat
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_NORM  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [17:0] v_q, v_d;        // working value, starts as phinc*2 (the fnum scale)
   logic [2:0]  blk_q, blk_d;    // shifts applied so far
   logic        rbit_q, rbit_d;  // last bit shifted out, used for half-up rounding
   logic [2:0]  block_q, block_d;
   logic [9:0]  fnum_q, fnum_d;
   logic        sat_q, sat_d;
   logic [11:0] r;               // one spare bit: at block 7 v[10:0]+rbit can reach 2048

   assign r = {1'b0, v_q[10:0]} + {11'd0, rbit_q};

   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      blk_d   = blk_q;
      rbit_d  = rbit_q;
      block_d = block_q;
      fnum_d  = fnum_q;
      sat_d   = sat_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               v_d     = {phinc_in, 1'b0};
               blk_d   = 3'd0;
               rbit_d  = 1'b0;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            if ((v_q[17:10] != 8'd0) && (blk_q != 3'd7)) begin
               v_d    = v_q >> 1;
               rbit_d = v_q[0];
               blk_d  = blk_q + 3'd1;
            end else begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            if (r <= 12'd1023) begin
               fnum_d  = r[9:0];
               block_d = blk_q;
               sat_d   = 1'b0;
            end else if (blk_q != 3'd7) begin
               // rounding carried into bit 10: renormalise one more octave
               fnum_d  = r[10:1];
               block_d = blk_q + 3'd1;
               sat_d   = 1'b0;
            end else begin
               fnum_d  = 10'd1023;
               block_d = 3'd7;
               sat_d   = 1'b1;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         v_q     <= 18'd0;
         blk_q   <= 3'd0;
         rbit_q  <= 1'b0;
         block_q <= 3'd0;
         fnum_q  <= 10'd0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         blk_q   <= blk_d;
         rbit_q  <= rbit_d;
         block_q <= block_d;
         fnum_q  <= fnum_d;
         sat_q   <= sat_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign block     = block_q;
   assign fnum      = fnum_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_jtopl_pg_enc.sv
// Testbench for jtopl_pg_enc: scoreboard of expected results pushed at accept
//   time, checked by an independent monitor on the falling edge. The reference
//   computes the encoding as a rounded division of 2*phinc by 2^block.
module tb_jtopl_pg_enc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [16:0] phinc_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  block;
   logic [9:0]  fnum;
   logic        sat;

   jtopl_pg_enc dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .phinc_in(phinc_in), .out_valid(out_valid), .out_ready(out_ready),
      .block(block), .fnum(fnum), .sat(sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      int p;
      int blk;
      int fn;
      int st;
      int lat;
      int acc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: smallest octave b with (2*p)/2^b < 1024, fnum = round-half-up
   // of 2*p/2^b, then a carry to 1024 moves up one octave or saturates.
   function automatic exp_t model(input int p);
      exp_t e;
      int t, b, f;
      t = 2 * p;
      b = 0;
      while (b < 7 && (t >> b) >= 1024) b++;
      f = (b == 0) ? t : ((t + (1 << (b - 1))) >> b);
      e.p = p; e.st = 0; e.lat = b + 2; e.acc = 0;
      if (f > 1023) begin
         if (b < 7) begin f = f / 2; b++; end
         else begin f = 1023; e.st = 1; end
      end
      e.blk = b; e.fn = f;
      return e;
   endfunction

   // ready driver
   initial begin
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // monitor
   initial begin
      exp_t cur;
      bit   seen;
      int   fwd, diff;
      seen = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 0;
         end else if (out_valid && !seen) begin
            seen = 1;
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
               cur.p = 0; cur.blk = block; cur.fn = fnum; cur.st = sat;
            end else begin
               cur = exp_q.pop_front();
               check($sformatf("block(p=%0d)", cur.p), int'(block), cur.blk);
               check($sformatf("fnum(p=%0d)", cur.p), int'(fnum), cur.fn);
               check($sformatf("sat(p=%0d)", cur.p), int'(sat), cur.st);
               check($sformatf("latency(p=%0d)", cur.p), cyc - cur.acc, cur.lat);
               if (!sat) begin
                  fwd  = (int'(fnum) << block) >> 1;
                  diff = (fwd > cur.p) ? fwd - cur.p : cur.p - fwd;
                  check($sformatf("fwd_err_ok(p=%0d)", cur.p),
                        int'(2 * diff <= (1 << block)), 1);
               end
            end
         end else if (out_valid && seen) begin
            if (block != cur.blk || fnum != cur.fn || sat != cur.st)
               check("held_outputs", {block, fnum, sat}, {cur.blk[2:0], cur.fn[9:0], cur.st[0]});
         end else begin
            seen = 0;
         end
      end
   end

   task automatic send(input int p);
      exp_t e;
      bit   ok;
      @(negedge clk);
      in_valid = 1'b1;
      phinc_in = p[16:0];
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) check("accept_timeout", 0, 1);
      e = model(p);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && in_ready) begin ok = 1; break; end
      end
      if (!ok) check("drain_timeout", 0, 1);
   endtask

   initial begin
      int dirs[8];
      exp_t tmp;
      bit ok;
      dirs = '{300, 1024, 1000, 2047, 65472, 70000, 0, 131071};

      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_outputs", {block, fnum, sat}, 0);
      rst_n = 1'b1;

      // directed points
      foreach (dirs[i]) begin
         send(dirs[i]);
         drain();
      end

      // reset in the middle of normalisation
      send(70000);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      tmp = exp_q.pop_front();
      #2;
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_outputs", {block, fnum, sat}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("postrst_out_valid", int'(out_valid), 0);
      check("postrst_in_ready", int'(in_ready), 1);

      // stalled consumer
      rdy_mode = 2;
      send(1000);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; break; end
      end
      if (!ok) check("stall_valid_timeout", 0, 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         phinc_in = 17'd5;
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_out_valid", int'(out_valid), 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rdy_mode = 0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_out_valid", int'(out_valid), 0);
      check("release_in_ready", int'(in_ready), 1);
      check("release_block_kept", int'(block), 1);
      check("release_fnum_kept", int'(fnum), 1000);
      @(negedge clk);
      check("ignored_req_not_taken", int'(in_ready), 1);

      // random sweep with a jittery consumer
      rdy_mode = 1;
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 3))
            0: send($urandom_range(0, 131071));
            1: send($urandom_range(0, 2047));
            2: send($urandom_range(65400, 65600));
            default: send((1 << $urandom_range(0, 16)) - $urandom_range(0, 1));
         endcase
         if ($urandom_range(0, 1) == 0) drain();
      end
      drain();
      rdy_mode = 0;
      repeat (4) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation ran past limit");
      $fatal(1);
   end

endmodule
